// File: rtl/flood_pkg.sv
// Shared types and constants for the Flood-It turn sequencer.
package flood_pkg;
    localparam int MAX_SIZE = 26;
    localparam int COLOR_W  = 3;
    localparam int MOVE_W   = 6;
    localparam int COORD_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_SCAN,
        ST_PLAY,
        ST_REQ,
        ST_FILL,
        ST_SCAN,
        ST_WON,
        ST_LOST
    } state_e;
endpackage

// File: rtl/flood_board_scanner.sv
// Row-major uniformity scan over the board read port; address in cycle k, compare in k+1.
// done_o/uniform_o are combinational on the compare cycle so the caller can register the result directly.
module flood_board_scanner #(
    parameter int COLOR_W = flood_pkg::COLOR_W,
    parameter int COORD_W = flood_pkg::COORD_W
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               capture_i,
    input  logic [COORD_W-1:0] size_i,
    input  logic [COLOR_W-1:0] target_i,
    output logic [COORD_W-1:0] rd_row_o,
    output logic [COORD_W-1:0] rd_col_o,
    input  logic [COLOR_W-1:0] rd_data_i,
    output logic               done_o,
    output logic               uniform_o,
    output logic [COLOR_W-1:0] corner_o
);
    logic [COORD_W-1:0] row_q, col_q;
    logic               issue_q, cmp_vld_q, pend_last_q, first_q, capture_q;
    logic [COLOR_W-1:0] target_q;
    logic               at_last, last_col, skip_cmp, mismatch;

    always_comb begin
        last_col  = (col_q == size_i - 1'b1);
        at_last   = last_col && (row_q == size_i - 1'b1);
        // In capture mode the first cell defines the target, so it cannot mismatch.
        skip_cmp  = capture_q && first_q;
        mismatch  = cmp_vld_q && !skip_cmp && (rd_data_i != target_q);
        done_o    = cmp_vld_q && (mismatch || pend_last_q);
        uniform_o = !mismatch;
        corner_o  = skip_cmp ? rd_data_i : target_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            row_q       <= '0;
            col_q       <= '0;
            issue_q     <= 1'b0;
            cmp_vld_q   <= 1'b0;
            pend_last_q <= 1'b0;
            first_q     <= 1'b0;
            capture_q   <= 1'b0;
            target_q    <= '0;
        end else if (start_i) begin
            row_q       <= '0;
            col_q       <= '0;
            issue_q     <= 1'b1;
            cmp_vld_q   <= 1'b0;
            pend_last_q <= 1'b0;
            first_q     <= 1'b1;
            capture_q   <= capture_i;
            target_q    <= target_i;
        end else if (done_o) begin
            row_q       <= '0;
            col_q       <= '0;
            issue_q     <= 1'b0;
            cmp_vld_q   <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            cmp_vld_q <= issue_q;
            if (issue_q) begin
                pend_last_q <= at_last;
                if (at_last) begin
                    issue_q <= 1'b0;
                end else if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (cmp_vld_q) begin
                first_q <= 1'b0;
                if (skip_cmp) target_q <= rd_data_i;
            end
        end
    end

    assign rd_row_o = row_q;
    assign rd_col_o = col_q;
endmodule

// File: rtl/flood_turn_ctrl.sv
// Flood-It turn sequencer: validates picks, hands them to the fill engine, counts moves, scans for win/loss.
// NEW_GAME during an engine fill is held until the engine goes idle, then the post-fill scan is skipped.
module flood_turn_ctrl #(
    parameter int MAX_SIZE = flood_pkg::MAX_SIZE,
    parameter int COLOR_W  = flood_pkg::COLOR_W,
    parameter int MOVE_W   = flood_pkg::MOVE_W
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic [flood_pkg::COORD_W-1:0] size_i,
    input  logic [3:0]                   color_num_i,
    input  logic [MOVE_W-1:0]            move_limit_i,
    input  logic                         new_game_i,
    input  logic                         btn_valid_i,
    input  logic [COLOR_W-1:0]           btn_color_i,
    output logic                         fill_req_o,
    output logic [COLOR_W-1:0]           fill_color_o,
    input  logic                         fill_busy_i,
    output logic [flood_pkg::COORD_W-1:0] rd_row_o,
    output logic [flood_pkg::COORD_W-1:0] rd_col_o,
    input  logic [COLOR_W-1:0]           rd_data_i,
    output logic                         ready_o,
    output logic [MOVE_W-1:0]            moves_o,
    output logic                         game_won_o,
    output logic                         game_lost_o
);
    import flood_pkg::*;

    state_e             state_q;
    logic [COLOR_W-1:0] cur_color_q, fill_color_q;
    logic [MOVE_W-1:0]  moves_q, limit_q;
    logic [COORD_W-1:0] size_q, size_eff;
    logic               fill_req_q, ready_q, won_q, lost_q, ng_pend_q;
    logic               new_ok, fill_end, go_init, go_scan, pick_ok;
    logic               scan_done, scan_uniform;
    logic [COLOR_W-1:0] scan_corner;

    always_comb begin
        size_eff = (size_i == '0 || size_i > COORD_W'(MAX_SIZE)) ? COORD_W'(MAX_SIZE) : size_i;
        new_ok   = new_game_i && (state_q inside {ST_IDLE, ST_INIT_SCAN, ST_PLAY,
                                                   ST_SCAN, ST_WON, ST_LOST});
        fill_end = (state_q == ST_FILL) && !fill_busy_i;
        go_init  = new_ok || (fill_end && (ng_pend_q || new_game_i));
        go_scan  = fill_end && !ng_pend_q && !new_game_i;
        pick_ok  = ({1'b0, btn_color_i} < color_num_i) && (btn_color_i != cur_color_q);
    end

    flood_board_scanner #(.COLOR_W(COLOR_W), .COORD_W(COORD_W)) u_scanner (
        .clk_i     (clock_i),
        .rst_n_i   (reset_n_i),
        .start_i   (go_init || go_scan),
        .capture_i (go_init),
        .size_i    (size_q),
        .target_i  (cur_color_q),
        .rd_row_o  (rd_row_o),
        .rd_col_o  (rd_col_o),
        .rd_data_i (rd_data_i),
        .done_o    (scan_done),
        .uniform_o (scan_uniform),
        .corner_o  (scan_corner)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            cur_color_q  <= '0;
            fill_color_q <= '0;
            moves_q      <= '0;
            limit_q      <= '0;
            size_q       <= COORD_W'(MAX_SIZE);
            fill_req_q   <= 1'b0;
            ready_q      <= 1'b0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
            ng_pend_q    <= 1'b0;
        end else begin
            if (new_game_i) begin
                size_q  <= size_eff;
                limit_q <= move_limit_i;
            end
            if (go_init) begin
                state_q    <= ST_INIT_SCAN;
                moves_q    <= '0;
                won_q      <= 1'b0;
                lost_q     <= 1'b0;
                ready_q    <= 1'b0;
                fill_req_q <= 1'b0;
                ng_pend_q  <= 1'b0;
            end else if (go_scan) begin
                state_q <= ST_SCAN;
            end else begin
                case (state_q)
                    ST_INIT_SCAN, ST_SCAN: begin
                        if (scan_done) begin
                            if (state_q == ST_INIT_SCAN) cur_color_q <= scan_corner;
                            // A uniform board wins even when the move budget is exhausted.
                            if (scan_uniform) begin
                                state_q <= ST_WON;
                                won_q   <= 1'b1;
                            end else if (moves_q == limit_q) begin
                                state_q <= ST_LOST;
                                lost_q  <= 1'b1;
                            end else begin
                                state_q <= ST_PLAY;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (btn_valid_i && pick_ok) begin
                            fill_color_q <= btn_color_i;
                            fill_req_q   <= 1'b1;
                            ready_q      <= 1'b0;
                            state_q      <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (new_game_i) ng_pend_q <= 1'b1;
                        if (fill_busy_i) begin
                            fill_req_q  <= 1'b0;
                            moves_q     <= moves_q + 1'b1;
                            cur_color_q <= fill_color_q;
                            state_q     <= ST_FILL;
                        end
                    end
                    ST_FILL: begin
                        if (new_game_i) ng_pend_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign fill_req_o   = fill_req_q;
    assign fill_color_o = fill_color_q;
    assign ready_o      = ready_q;
    assign moves_o      = moves_q;
    assign game_won_o   = won_q;
    assign game_lost_o  = lost_q;
endmodule

// File: tb/tb_flood_turn_ctrl.sv
// Directed bench for flood_turn_ctrl with a registered board memory and a scripted fill engine.
module tb_flood_turn_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] size;
    logic [3:0] color_num;
    logic [5:0] move_limit;
    logic       new_game, btn_valid, fill_busy;
    logic [2:0] btn_color, rd_data, fill_color;
    logic       fill_req, ready, won, lost;
    logic [4:0] rd_row, rd_col;
    logic [5:0] moves;

    logic [2:0] board [0:25][0:25];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flood_turn_ctrl dut (
        .clock_i      (clk),
        .reset_n_i    (reset_n),
        .size_i       (size),
        .color_num_i  (color_num),
        .move_limit_i (move_limit),
        .new_game_i   (new_game),
        .btn_valid_i  (btn_valid),
        .btn_color_i  (btn_color),
        .fill_req_o   (fill_req),
        .fill_color_o (fill_color),
        .fill_busy_i  (fill_busy),
        .rd_row_o     (rd_row),
        .rd_col_o     (rd_col),
        .rd_data_i    (rd_data),
        .ready_o      (ready),
        .moves_o      (moves),
        .game_won_o   (won),
        .game_lost_o  (lost)
    );

    // Synchronous read: data for the address of cycle k is presented in cycle k+1.
    always @(posedge clk) rd_data <= board[rd_row][rd_col];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_board(input logic [2:0] c);
        for (int r = 0; r < 26; r++)
            for (int k = 0; k < 26; k++)
                board[r][k] = c;
    endtask

    task automatic set_board2(input logic [2:0] b0, b1, b2, b3);
        board[0][0] = b0;
        board[0][1] = b1;
        board[1][0] = b2;
        board[1][1] = b3;
    endtask

    task automatic start_game(input logic [4:0] sz, input logic [5:0] lim);
        size       = sz;
        move_limit = lim;
        new_game   = 1'b1;
        tick();
        new_game   = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while (!(ready || won || lost) && n < 100) begin
            tick();
            n++;
        end
        check("settle", 32'(ready | won | lost), 1);
    endtask

    task automatic pick(input logic [2:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        tick();
        btn_valid = 1'b0;
    endtask

    // One accepted move: engine raises busy two cycles after the request, repaints, then idles.
    task automatic move(input logic [2:0] c, input logic [2:0] b0, b1, b2, b3,
                        input logic [5:0] exp_moves);
        pick(c);
        check("mv_req", 32'(fill_req), 1);
        check("mv_rdy", 32'(ready), 0);
        check("mv_col", 32'(fill_color), 32'(c));
        tick();
        fill_busy = 1'b1;
        tick();
        check("mv_req_drop", 32'(fill_req), 0);
        check("mv_moves", 32'(moves), 32'(exp_moves));
        set_board2(b0, b1, b2, b3);
        tick();
        fill_busy = 1'b0;
        tick();
        settle();
    endtask

    initial begin
        logic seen_req;
        reset_n = 1'b0; size = 5'd2; color_num = 4'd4; move_limit = 6'd5;
        new_game = 1'b0; btn_valid = 1'b0; btn_color = 3'd0; fill_busy = 1'b0;
        fill_board(3'd0);
        tick();
        tick();
        check("rst_req", 32'(fill_req), 0);
        check("rst_fcol", 32'(fill_color), 0);
        check("rst_row", 32'(rd_row), 0);
        check("rst_col", 32'(rd_col), 0);
        check("rst_rdy", 32'(ready), 0);
        check("rst_moves", 32'(moves), 0);
        check("rst_won", 32'(won), 0);
        check("rst_lost", 32'(lost), 0);
        reset_n = 1'b1;
        tick();

        // 6x6 uniform board: win after 37 cycles without any fill request
        fill_board(3'd2);
        start_game(5'd6, 6'd5);
        check("u6_row0", 32'(rd_row), 0);
        check("u6_col0", 32'(rd_col), 0);
        tick();
        check("u6_col1", 32'(rd_col), 1);
        seen_req = 1'b0;
        for (int i = 2; i <= 37; i++) begin
            tick();
            if (fill_req) seen_req = 1'b1;
            if (i == 36) check("u6_won_t36", 32'(won), 0);
        end
        check("u6_won_t37", 32'(won), 1);
        check("u6_moves", 32'(moves), 0);
        check("u6_noreq", 32'(seen_req), 0);
        check("u6_rdy", 32'(ready), 0);

        // 1x1 board: two-cycle scan
        start_game(5'd1, 6'd5);
        check("u1_clear", 32'(won), 0);
        tick();
        check("u1_t1", 32'(won), 0);
        tick();
        check("u1_t2", 32'(won), 1);

        // 2x2 {1,3,1,1}: mismatch at index 1 ends after 3 cycles
        set_board2(3'd1, 3'd3, 3'd1, 3'd1);
        start_game(5'd2, 6'd5);
        tick();
        tick();
        check("b2_rdy_t2", 32'(ready), 0);
        tick();
        check("b2_rdy_t3", 32'(ready), 1);
        pick(3'd5);
        tick();
        check("rej5_req", 32'(fill_req), 0);
        check("rej5_rdy", 32'(ready), 1);
        check("rej5_moves", 32'(moves), 0);
        pick(3'd1);
        tick();
        check("rejc_req", 32'(fill_req), 0);
        check("rejc_rdy", 32'(ready), 1);
        move(3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 6'd1);
        check("b2_won", 32'(won), 1);
        check("b2_lost", 32'(lost), 0);
        check("b2_moves", 32'(moves), 1);
        check("b2_fcol", 32'(fill_color), 3);

        // Move limit 2 with the board left mixed: loss
        set_board2(3'd0, 3'd1, 3'd1, 3'd1);
        start_game(5'd2, 6'd2);
        settle();
        move(3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 6'd1);
        check("lim_mid_rdy", 32'(ready), 1);
        check("lim_mid_lost", 32'(lost), 0);
        move(3'd3, 3'd3, 3'd1, 3'd1, 3'd1, 6'd2);
        check("lim_lost", 32'(lost), 1);
        check("lim_won", 32'(won), 0);
        check("lim_rdy", 32'(ready), 0);

        // Same limit, last move makes the board uniform: win beats the limit
        set_board2(3'd0, 3'd1, 3'd1, 3'd1);
        start_game(5'd2, 6'd2);
        check("lim2_clr", 32'(lost), 0);
        settle();
        move(3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 6'd1);
        move(3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 6'd2);
        check("lim2_won", 32'(won), 1);
        check("lim2_lost", 32'(lost), 0);

        // NEW_GAME while the engine is busy: held, then INIT_SCAN instead of SCAN
        set_board2(3'd0, 3'd1, 3'd1, 3'd1);
        start_game(5'd2, 6'd5);
        settle();
        pick(3'd2);
        tick();
        fill_busy = 1'b1;
        tick();
        check("ng_moves1", 32'(moves), 1);
        set_board2(3'd2, 3'd1, 3'd1, 3'd1);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check("ng_latched", 32'(moves), 1);
        tick();
        fill_busy = 1'b0;
        tick();
        check("ng_moves0", 32'(moves), 0);
        check("ng_col0", 32'(rd_col), 0);
        tick();
        check("ng_col1", 32'(rd_col), 1);
        tick();
        check("ng_rdy_t2", 32'(ready), 0);
        tick();
        check("ng_rdy_t3", 32'(ready), 1);
        check("ng_won", 32'(won), 0);

        // Reset while a request is outstanding
        move(3'd3, 3'd3, 3'd1, 3'd1, 3'd1, 6'd1);
        pick(3'd0);
        check("rq_req", 32'(fill_req), 1);
        reset_n = 1'b0;
        tick();
        check("rq_req0", 32'(fill_req), 0);
        check("rq_fcol", 32'(fill_color), 0);
        check("rq_rdy", 32'(ready), 0);
        check("rq_moves", 32'(moves), 0);
        check("rq_won", 32'(won), 0);
        check("rq_lost", 32'(lost), 0);
        check("rq_row", 32'(rd_row), 0);
        check("rq_col", 32'(rd_col), 0);
        reset_n = 1'b1;
        tick();
        pick(3'd2);
        tick();
        check("idle_btn_req", 32'(fill_req), 0);
        check("idle_rdy", 32'(ready), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
